// File: rtl/alu_divider_if.sv
// Request/response bundle between the CPU ALU (master) and the iterative divider (slave).
interface alu_divider_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic             signed_i;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] quotient_o;
    logic [WIDTH-1:0] remainder_o;

    modport master (
        output start_i, signed_i, dividend_i, divisor_i,
        input  busy_o, done_o, quotient_o, remainder_o
    );

    modport slave (
        input  start_i, signed_i, dividend_i, divisor_i,
        output busy_o, done_o, quotient_o, remainder_o
    );
endinterface

// File: rtl/alu_divider.sv
// Radix-2 restoring divider for DIV/DIVU: 32 steps on operand magnitudes, then sign fixup.
// Define DIV_EARLY_EXIT_EN to finish divide-by-zero and |dividend| < |divisor| in one cycle.
module alu_divider #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_divider_if.slave  div
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] rem_reg, quo_reg, dvs_reg, dvd_raw_reg;
    logic             q_neg_reg, r_neg_reg, dz_reg;
    logic             done_reg;
    logic [WIDTH-1:0] quotient_reg, remainder_reg;

    logic             dvd_neg, dvs_neg, dz, early_exit, accept;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH:0]   shifted, trial;
    logic             step_ok;
    logic [WIDTH-1:0] rem_step, quo_step;
    logic             busy;
    logic [WIDTH-1:0] q_final, r_final;

    assign dvd_neg = div.signed_i & div.dividend_i[WIDTH-1];
    assign dvs_neg = div.signed_i & div.divisor_i[WIDTH-1];
    assign dvd_mag = dvd_neg ? -div.dividend_i : div.dividend_i;
    assign dvs_mag = dvs_neg ? -div.divisor_i : div.divisor_i;
    assign dz      = (div.divisor_i == '0);
    assign accept  = (state_reg == IDLE) && div.start_i;

`ifdef DIV_EARLY_EXIT_EN
    assign early_exit = dz | (dvd_mag < dvs_mag);
`else
    assign early_exit = 1'b0;
`endif

    // One restoring step: the bit shifted out of quo feeds the 33-bit partial remainder.
    assign shifted  = {rem_reg, quo_reg[WIDTH-1]};
    assign trial    = shifted - {1'b0, dvs_reg};
    assign step_ok  = ~trial[WIDTH];
    assign rem_step = step_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_step = {quo_reg[WIDTH-2:0], step_ok};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (div.start_i) state_next = early_exit ? FIN : RUN;
            RUN:     if (cnt_reg == CW'(WIDTH - 1)) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_reg != IDLE);
        q_final = q_neg_reg ? -quo_reg : quo_reg;
        r_final = r_neg_reg ? -rem_reg : rem_reg;
        // Divide by zero bypasses the fixup and returns the raw dividend.
        if (dz_reg) begin
            q_final = '1;
            r_final = dvd_raw_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg       <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            dvs_reg       <= '0;
            dvd_raw_reg   <= '0;
            q_neg_reg     <= 1'b0;
            r_neg_reg     <= 1'b0;
            dz_reg        <= 1'b0;
            done_reg      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
        end else begin
            done_reg <= (state_reg == FIN);
            if (accept) begin
                cnt_reg     <= '0;
                // An early exit preloads the final answer: quotient 0, remainder |dividend|.
                quo_reg     <= early_exit ? '0 : dvd_mag;
                rem_reg     <= early_exit ? dvd_mag : '0;
                dvs_reg     <= dvs_mag;
                dvd_raw_reg <= div.dividend_i;
                q_neg_reg   <= dvd_neg ^ dvs_neg;
                r_neg_reg   <= dvd_neg;
                dz_reg      <= dz;
            end else if (state_reg == RUN) begin
                cnt_reg <= cnt_reg + 1'b1;
                rem_reg <= rem_step;
                quo_reg <= quo_step;
            end else if (state_reg == FIN) begin
                quotient_reg  <= q_final;
                remainder_reg <= r_final;
            end
        end
    end

    assign div.busy_o      = busy;
    assign div.done_o      = done_reg;
    assign div.quotient_o  = quotient_reg;
    assign div.remainder_o = remainder_reg;
endmodule

// File: tb/tb_alu_divider.sv
// Directed bench for alu_divider: scoreboard of expected quotient/remainder, latency and handshake checks.
module tb_alu_divider;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_divider_if #(.WIDTH(32)) dif();

    alu_divider #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .div   (dif)
    );

`ifdef DIV_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   done_cyc_last = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input bit sg, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (b == 32'h0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
        end else if (sg) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.q = 32'h8000_0000;
                e.r = 32'h0;
            end else begin
                e.q = 32'($signed(a) / $signed(b));
                e.r = 32'($signed(a) % $signed(b));
            end
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    function automatic int exp_lat(input bit sg, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb;
        ma = (sg && a[31]) ? -a : a;
        mb = (sg && b[31]) ? -b : b;
        if (EARLY && (b == 32'h0 || ma < mb)) return 1;
        return 33;
    endfunction

    // Starts at a negedge, returns at the negedge where done_o was seen (or after the bound).
    task automatic run_op(input string tag, input bit sg, input logic [31:0] a,
                          input logic [31:0] b, input int intr_at);
        exp_t        e;
        int          lat, busy_n, want;
        bit          overlap;
        logic [31:0] prev_q;
        e = model(sg, a, b);
        sb.push_back(e);
        want   = exp_lat(sg, a, b);
        prev_q = dif.quotient_o;
        dif.start_i    = 1'b1;
        dif.signed_i   = sg;
        dif.dividend_i = a;
        dif.divisor_i  = b;
        @(posedge clk);
        @(negedge clk);
        dif.start_i    = 1'b0;
        dif.signed_i   = ~sg;
        dif.dividend_i = $urandom;
        dif.divisor_i  = $urandom;
        check($sformatf("%s busy_after_start", tag), {31'b0, dif.busy_o}, 32'd1);
        check($sformatf("%s q_held", tag), dif.quotient_o, prev_q);
        lat = 0;
        busy_n = 0;
        overlap = 1'b0;
        while (lat < 100) begin
            if (lat == intr_at) begin
                dif.start_i    = 1'b1;
                dif.signed_i   = 1'b0;
                dif.dividend_i = 32'd9;
                dif.divisor_i  = 32'd3;
            end
            @(posedge clk);
            @(negedge clk);
            dif.start_i = 1'b0;
            lat++;
            if (dif.busy_o && dif.done_o) overlap = 1'b1;
            if (dif.done_o) break;
            if (dif.busy_o) busy_n++;
        end
        check($sformatf("%s latency", tag), lat, want);
        check($sformatf("%s busy_cycles", tag), busy_n, want - 1);
        check($sformatf("%s busy_done_overlap", tag), {31'b0, overlap}, 32'd0);
        e = sb.pop_front();
        if (dif.done_o) begin
            check($sformatf("%s quotient", tag), dif.quotient_o, e.q);
            check($sformatf("%s remainder", tag), dif.remainder_o, e.r);
            done_cyc_last = cyc;
        end
        $display("op %s sg=%0d %h / %h -> q=%h r=%h lat=%0d", tag, sg, a, b,
                 dif.quotient_o, dif.remainder_o, lat);
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (dif.done_o) cnt++;
        end
    endtask

    initial begin
        int t1, nd;
        logic [31:0] ra, rb;
        dif.start_i    = 1'b0;
        dif.signed_i   = 1'b0;
        dif.dividend_i = 32'h0;
        dif.divisor_i  = 32'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset busy", {31'b0, dif.busy_o}, 32'd0);
        check("reset done", {31'b0, dif.done_o}, 32'd0);
        check("reset quotient", dif.quotient_o, 32'h0);
        check("reset remainder", dif.remainder_o, 32'h0);

        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, -1);
        t1 = done_cyc_last;
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, -1);
        check("back_to_back_interval", done_cyc_last - t1, 32'd34);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, -1);
        run_op("div_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op("divu_by_zero", 1'b0, 32'h1234_5678, 32'h0, -1);
        run_op("div_by_zero_neg", 1'b1, 32'hFFFF_FF00, 32'h0, -1);
        run_op("divu_3_10", 1'b0, 32'd3, 32'd10, -1);
        run_op("div_m3_10", 1'b1, 32'hFFFF_FFFD, 32'd10, -1);
        run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, -1);
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom_range(1, 70000);
            run_op($sformatf("rand%0d", i), i[0], ra, rb, -1);
        end

        repeat (3) @(negedge clk);
        run_op("ignored_start", 1'b0, 32'd50, 32'd5, 10);
        count_dones(40, nd);
        check("ignored_start extra_done", nd, 32'd0);

        dif.start_i    = 1'b1;
        dif.signed_i   = 1'b0;
        dif.dividend_i = 32'hDEAD_BEEF;
        dif.divisor_i  = 32'd3;
        @(posedge clk);
        @(negedge clk);
        dif.start_i = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'b0, dif.busy_o}, 32'd0);
        check("abort done", {31'b0, dif.done_o}, 32'd0);
        check("abort quotient", dif.quotient_o, 32'h0);
        check("abort remainder", dif.remainder_o, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_dones(40, nd);
        check("abort no_done", nd, 32'd0);
        $display("op abort DEADBEEF/3 -> dones after reset=%0d", nd);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
